// File: rtl/jt900h_intc_pkg.sv
// Shared constants for the JT900H interrupt controller: register map and FSM encoding.
package jt900h_intc_pkg;

   localparam int unsigned NSRC  = 8;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned LVL_W = 3;

   localparam logic [3:0] REG_PRIO0 = 4'd0;
   localparam logic [3:0] REG_EDGE  = 4'd8;
   localparam logic [3:0] REG_CTRL  = 4'd9;
   localparam logic [3:0] REG_PEND  = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

endpackage

// File: rtl/jt900h_intc_arb.sv
// Combinational 8-way arbiter: highest level wins, ties go to the lowest index.
module jt900h_intc_arb
   import jt900h_intc_pkg::*;
(
   input  logic [NSRC-1:0]       cand,
   input  logic [NSRC*LVL_W-1:0] prio,
   output logic [IDX_W-1:0]      idx,
   output logic [LVL_W-1:0]      lvl,
   output logic                  valid
);

   // Scan downward with >= so a lower index overrides an equal level
   always_comb begin
      idx   = '0;
      lvl   = '0;
      valid = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (cand[i] && prio[i*LVL_W +: LVL_W] != '0 && prio[i*LVL_W +: LVL_W] >= lvl) begin
            idx   = IDX_W'(i);
            lvl   = prio[i*LVL_W +: LVL_W];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/jt900h_intc.sv
// JT900H interrupt controller: latches sources, arbitrates by priority and presents one request.
module jt900h_intc
   import jt900h_intc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   input  logic [7:0] src,
   input  logic       cfg_we,
   input  logic [3:0] cfg_addr,
   input  logic [7:0] cfg_din,
   output logic [7:0] cfg_dout,
   output logic       irq,
   output logic [2:0] intrq,
   output logic       inta_en,
   output logic [7:0] int_addr,
   input  logic       irq_ack
);

   logic [LVL_W-1:0]      prio [NSRC];
   logic [NSRC*LVL_W-1:0] prio_flat;
   logic [NSRC-1:0]       edge_cfg;
   logic [2:0]            vbase;
   logic [NSRC-1:0]       src_q, pend, pend_n, rise, ack_clr, wr_clr;
   logic [IDX_W-1:0]      win_idx, win_idx_n, arb_idx;
   logic [LVL_W-1:0]      win_lvl, win_lvl_n, arb_lvl;
   logic                  arb_valid, irq_n;
   logic [7:0]            int_addr_n;
   state_t                state, state_n;

   always_comb begin
      prio_flat = '0;
      for (int i = 0; i < NSRC; i++) prio_flat[i*LVL_W +: LVL_W] = prio[i];
   end

   jt900h_intc_arb u_arb (
      .cand  (pend),
      .prio  (prio_flat),
      .idx   (arb_idx),
      .lvl   (arb_lvl),
      .valid (arb_valid)
   );

   // Edge bits: set on rise, cleared by ack or PEND write; level bits follow src
   always_comb begin
      rise    = src & ~src_q;
      ack_clr = (state == ST_REQ && irq_ack) ? (NSRC'(1) << win_idx) : '0;
      wr_clr  = (cfg_we && cfg_addr == REG_PEND) ? cfg_din : '0;
      pend_n  = (edge_cfg & ((pend & ~ack_clr & ~wr_clr) | rise)) | (~edge_cfg & src);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NSRC; i++) prio[i] <= '0;
         edge_cfg <= '0;
         inta_en  <= 1'b0;
         vbase    <= '0;
         src_q    <= '0;
         pend     <= '0;
      end else if (cen) begin
         src_q <= src;
         pend  <= pend_n;
         if (cfg_we) begin
            if (!cfg_addr[3]) prio[cfg_addr[2:0]] <= cfg_din[2:0];
            else if (cfg_addr == REG_EDGE) edge_cfg <= cfg_din;
            else if (cfg_addr == REG_CTRL) begin
               inta_en <= cfg_din[7];
               vbase   <= cfg_din[2:0];
            end
         end
      end
   end

   always_comb begin
      cfg_dout = '0;
      if (!cfg_addr[3]) cfg_dout = {5'b0, prio[cfg_addr[2:0]]};
      else begin
         case (cfg_addr)
            REG_EDGE: cfg_dout = edge_cfg;
            REG_CTRL: cfg_dout = {inta_en, 4'b0, vbase};
            REG_PEND: cfg_dout = pend;
            default:  cfg_dout = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)   state <= ST_IDLE;
      else if (cen) state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (arb_valid) state_n = ST_REQ;
         ST_REQ: begin
            if (irq_ack)         state_n = ST_ACK;
            else if (!arb_valid) state_n = ST_IDLE;
         end
         ST_ACK:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Next presented request; REQ re-arbitrates every cycle so a stronger arrival takes over
   always_comb begin
      irq_n      = irq;
      win_idx_n  = win_idx;
      win_lvl_n  = win_lvl;
      int_addr_n = int_addr;
      case (state)
         ST_IDLE, ST_REQ: begin
            if (state == ST_REQ && irq_ack) irq_n = 1'b0;
            else if (arb_valid) begin
               irq_n      = 1'b1;
               win_idx_n  = arb_idx;
               win_lvl_n  = arb_lvl;
               int_addr_n = {vbase, arb_idx, 2'b00};
            end else irq_n = 1'b0;
         end
         default: irq_n = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq      <= 1'b0;
         win_idx  <= '0;
         win_lvl  <= '0;
         int_addr <= '0;
      end else if (cen) begin
         irq      <= irq_n;
         win_idx  <= win_idx_n;
         win_lvl  <= win_lvl_n;
         int_addr <= int_addr_n;
      end
   end

   assign intrq = win_lvl;

endmodule

// File: tb/tb_jt900h_intc.sv
// Directed bench for jt900h_intc: register table plus hand-written interrupt sequences.
module tb_jt900h_intc;

   logic       clk = 1'b0;
   logic       rst_n, cen, cfg_we, irq_ack;
   logic [7:0] src, cfg_din, cfg_dout, int_addr;
   logic [3:0] cfg_addr;
   logic       irq, inta_en;
   logic [2:0] intrq;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   jt900h_intc dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .src      (src),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_din  (cfg_din),
      .cfg_dout (cfg_dout),
      .irq      (irq),
      .intrq    (intrq),
      .inta_en  (inta_en),
      .int_addr (int_addr),
      .irq_ack  (irq_ack)
   );

   typedef struct {
      logic       cen;
      logic       we;
      logic [3:0] addr;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
      cfg_addr = a;
      #1;
      chk(name, cfg_dout, exp);
   endtask

   task automatic do_ack();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; cen = 1'b1; src = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_din = '0; irq_ack = 1'b0;
      vecs[0] = '{1'b1, 1'b1, 4'd0,  8'hFF, 8'h07};
      vecs[1] = '{1'b1, 1'b1, 4'd8,  8'hA5, 8'hA5};
      vecs[2] = '{1'b1, 1'b1, 4'd9,  8'hFF, 8'h87};
      vecs[3] = '{1'b1, 1'b1, 4'd10, 8'hFF, 8'h00};
      vecs[4] = '{1'b1, 1'b1, 4'd11, 8'hFF, 8'h00};
      vecs[5] = '{1'b0, 1'b1, 4'd1,  8'h05, 8'h00};
      vecs[6] = '{1'b1, 1'b1, 4'd7,  8'h0A, 8'h02};
      vecs[7] = '{1'b1, 1'b1, 4'd15, 8'h12, 8'h00};

      step();
      do_reset();
      chk("rst_irq", {7'b0, irq}, 8'h00);
      chk("rst_intrq", {5'b0, intrq}, 8'h00);
      chk("rst_inta_en", {7'b0, inta_en}, 8'h00);
      chk("rst_int_addr", int_addr, 8'h00);
      for (int a = 0; a < 11; a++) rd_chk("rst_reg", 4'(a), 8'h00);

      // Register write/readback table
      for (int i = 0; i < 8; i++) begin
         cen = vecs[i].cen; cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_din = vecs[i].din;
         step();
         cfg_we = 1'b0; cen = 1'b1;
         rd_chk("reg_table", vecs[i].addr, vecs[i].exp);
      end
      chk("inta_en_cfg", {7'b0, inta_en}, 8'h01);

      // Edge source 0 basic request/ack
      do_reset();
      wr(4'd8, 8'h01); wr(4'd0, 8'h03); wr(4'd9, 8'h85);
      src = 8'h01; step(); src = 8'h00;
      chk("t1_irq_n1", {7'b0, irq}, 8'h00);
      rd_chk("t1_pend_n1", 4'd10, 8'h01);
      step();
      chk("t1_irq_n2", {7'b0, irq}, 8'h01);
      chk("t1_intrq", {5'b0, intrq}, 8'h03);
      chk("t1_int_addr", int_addr, 8'hA0);
      chk("t1_inta_en", {7'b0, inta_en}, 8'h01);
      do_ack();
      chk("t1_irq_ack", {7'b0, irq}, 8'h00);
      rd_chk("t1_pend_ack", 4'd10, 8'h00);
      step(); step();
      chk("t1_irq_idle", {7'b0, irq}, 8'h00);

      // Tie on level 2: index 2 first, then 5
      wr(4'd2, 8'h02); wr(4'd5, 8'h02); wr(4'd8, 8'h25);
      src = 8'h24; step(); src = 8'h00; step();
      chk("t2_irq", {7'b0, irq}, 8'h01);
      chk("t2_addr_2", int_addr, 8'hA8);
      chk("t2_intrq", {5'b0, intrq}, 8'h02);
      do_ack();
      chk("t2_irq_ack", {7'b0, irq}, 8'h00);
      step();
      chk("t2_irq_ackst", {7'b0, irq}, 8'h00);
      step();
      chk("t2_irq_re", {7'b0, irq}, 8'h01);
      chk("t2_addr_5", int_addr, 8'hB4);
      do_ack(); step(); step();
      chk("t2_irq_done", {7'b0, irq}, 8'h00);
      rd_chk("t2_pend", 4'd10, 8'h00);

      // Higher priority preempts the presented request
      wr(4'd1, 8'h01); wr(4'd4, 8'h06); wr(4'd8, 8'h37);
      src = 8'h02; step(); src = 8'h00; step();
      chk("t3_intrq_1", {5'b0, intrq}, 8'h01);
      chk("t3_addr_1", int_addr, 8'hA4);
      src = 8'h10; step(); src = 8'h00; step();
      chk("t3_irq_pre", {7'b0, irq}, 8'h01);
      chk("t3_intrq_6", {5'b0, intrq}, 8'h06);
      chk("t3_addr_4", int_addr, 8'hB0);
      do_ack();
      rd_chk("t3_pend", 4'd10, 8'h02);
      step(); step();
      chk("t3_irq_re", {7'b0, irq}, 8'h01);
      chk("t3_intrq_re", {5'b0, intrq}, 8'h01);
      do_ack(); step(); step();
      chk("t3_irq_done", {7'b0, irq}, 8'h00);

      // Level source 3 survives ack and drops without ack
      wr(4'd3, 8'h04);
      src = 8'h08; step(); step();
      chk("t4_irq", {7'b0, irq}, 8'h01);
      chk("t4_intrq", {5'b0, intrq}, 8'h04);
      chk("t4_addr", int_addr, 8'hAC);
      do_ack();
      chk("t4_irq_ack", {7'b0, irq}, 8'h00);
      rd_chk("t4_pend", 4'd10, 8'h08);
      step(); step();
      chk("t4_irq_re", {7'b0, irq}, 8'h01);
      src = 8'h00; step(); step();
      chk("t4_irq_drop", {7'b0, irq}, 8'h00);

      // Ack coinciding with a new edge on the same source keeps it pending
      src = 8'h01; step(); src = 8'h00; step();
      chk("t5_irq", {7'b0, irq}, 8'h01);
      chk("t5_addr", int_addr, 8'hA0);
      src = 8'h01; do_ack(); src = 8'h00;
      chk("t5_irq_ack", {7'b0, irq}, 8'h00);
      rd_chk("t5_pend_kept", 4'd10, 8'h01);
      step(); step();
      chk("t5_irq_re", {7'b0, irq}, 8'h01);
      do_ack(); step(); step();
      chk("t5_irq_done", {7'b0, irq}, 8'h00);

      // PEND write clears an edge source and returns to IDLE
      wr(4'd6, 8'h05); wr(4'd8, 8'h77);
      src = 8'h40; step(); src = 8'h00; step();
      chk("t6_irq", {7'b0, irq}, 8'h01);
      chk("t6_intrq", {5'b0, intrq}, 8'h05);
      wr(4'd10, 8'h40);
      rd_chk("t6_pend", 4'd10, 8'h00);
      step();
      chk("t6_irq_idle", {7'b0, irq}, 8'h00);

      // Reset while requesting
      src = 8'h40; step(); src = 8'h00; step();
      chk("t7_irq", {7'b0, irq}, 8'h01);
      rst_n = 1'b0; step();
      chk("t7_rst_irq", {7'b0, irq}, 8'h00);
      chk("t7_rst_intrq", {5'b0, intrq}, 8'h00);
      chk("t7_rst_addr", int_addr, 8'h00);
      chk("t7_rst_inta", {7'b0, inta_en}, 8'h00);
      rd_chk("t7_rst_prio6", 4'd6, 8'h00);
      rst_n = 1'b1; step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
